// File: rtl/fifo8x9_ctrl.sv
// Sequencing controller for the 8x9 FIFO datapath.
// Occupancy tracking, access gating, sticky error flags.
module fifo8x9_ctrl #(
  parameter int DEPTH     = 8,
  parameter int AFULL_LVL = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_req,
  input  logic       rd_req,
  input  logic       flush,
  output logic       wr_ack,
  output logic       rd_ack,
  output logic       wren,
  output logic       WrInc,
  output logic       rden,
  output logic       RdInc,
  output logic       WrPtrClr,
  output logic       RdPtrClr,
  output logic [3:0] count,
  output logic       full,
  output logic       empty,
  output logic       almost_full,
  output logic       overflow,
  output logic       underflow
);

  typedef enum logic [1:0] {
    INIT,
    RUN,
    FLUSH
  } state_t;

  state_t     state;
  logic [3:0] cnt;
  logic       run;
  logic       wr_ok;
  logic       rd_ok;
  logic       ovf;
  logic       unf;

  assign run         = (state == RUN);
  assign count       = cnt;
  assign full        = (cnt == 4'(DEPTH));
  assign empty       = (cnt == 4'd0);
  assign almost_full = (cnt >= 4'(AFULL_LVL));
  assign overflow    = ovf;
  assign underflow   = unf;

  // No empty bypass; a full FIFO accepts a write only alongside a read
  assign rd_ok  = !empty;
  assign rd_ack = run & rd_req & rd_ok & !flush;
  assign wr_ok  = !full | rd_ack;
  assign wr_ack = run & wr_req & wr_ok & !flush;

  assign wren     = wr_ack;
  assign WrInc    = wr_ack;
  assign rden     = rd_ack;
  assign RdInc    = rd_ack;
  assign WrPtrClr = !run;
  assign RdPtrClr = !run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT;
      cnt   <= 4'd0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      unique case (state)
        INIT: begin
          state <= RUN;
        end
        RUN: begin
          if (flush)
            state <= FLUSH;
          if (wr_ack & !rd_ack)
            cnt <= cnt + 4'd1;
          else if (rd_ack & !wr_ack)
            cnt <= cnt - 4'd1;
          if (wr_req & !wr_ok & !flush)
            ovf <= 1'b1;
          if (rd_req & !rd_ok & !flush)
            unf <= 1'b1;
        end
        FLUSH: begin
          cnt   <= 4'd0;
          ovf   <= 1'b0;
          unf   <= 1'b0;
          state <= flush ? FLUSH : RUN;
        end
        default: begin
          state <= INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo8x9_ctrl.sv
// Randomised scoreboard bench for fifo8x9_ctrl with a
// queue-based reference model and a behavioural datapath.
module tb_fifo8x9_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_req;
  logic       rd_req;
  logic       flush;
  logic       wr_ack;
  logic       rd_ack;
  logic       wren;
  logic       WrInc;
  logic       rden;
  logic       RdInc;
  logic       WrPtrClr;
  logic       RdPtrClr;
  logic [3:0] count;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       overflow;
  logic       underflow;

  always #5 clk = ~clk;

  fifo8x9_ctrl #(.DEPTH(8), .AFULL_LVL(6)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .wr_req(wr_req),
    .rd_req(rd_req),
    .flush(flush),
    .wr_ack(wr_ack),
    .rd_ack(rd_ack),
    .wren(wren),
    .WrInc(WrInc),
    .rden(rden),
    .RdInc(RdInc),
    .WrPtrClr(WrPtrClr),
    .RdPtrClr(RdPtrClr),
    .count(count),
    .full(full),
    .empty(empty),
    .almost_full(almost_full),
    .overflow(overflow),
    .underflow(underflow)
  );

  // Behavioural 8x9 datapath driven by the controller strobes
  logic [8:0] mem [8];
  logic [2:0] wp = 3'd0;
  logic [2:0] rp = 3'd0;
  logic [8:0] din;
  logic [8:0] dout;

  always @(posedge clk) begin
    if (wren)
      mem[wp] <= din;
    if (WrPtrClr)
      wp <= 3'd0;
    else if (WrInc)
      wp <= wp + 3'd1;
    if (RdPtrClr)
      rp <= 3'd0;
    else if (RdInc)
      rp <= rp + 3'd1;
  end

  assign dout = mem[rp];

  typedef struct {
    logic [16:0] v;
    bit          rd;
    logic [8:0]  data;
    int          cyc;
  } exp_t;

  exp_t       exp_q[$];
  logic [8:0] mq[$];
  bit         m_ovf;
  bit         m_unf;
  int         phase;
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;

  function automatic logic [16:0] mk(bit wa, bit ra, bit clr,
                                     int n, bit ov, bit un);
    return {wa, wa, wa, ra, ra, ra, clr, clr, 4'(n),
            n == 8, n == 0, n >= 6, ov, un};
  endfunction

  // phase: 0 = accepting, 1 = post-reset init, 2 = flushing
  task automatic step(input bit w, input bit r, input bit f,
                      input bit rs, input logic [8:0] d);
    exp_t e;
    bit   wa;
    bit   ra;
    int   n;
    wr_req = w;
    rd_req = r;
    flush  = f;
    rst_n  = rs;
    din    = d;
    n      = mq.size();
    e.rd   = 1'b0;
    e.data = 9'd0;
    e.cyc  = cyc;
    if (!rs) begin
      e.v = mk(0, 0, 1, 0, 0, 0);
      mq.delete();
      m_ovf = 0;
      m_unf = 0;
      phase = 1;
    end else if (phase != 0) begin
      e.v = mk(0, 0, 1, n, m_ovf, m_unf);
      if (phase == 2) begin
        mq.delete();
        m_ovf = 0;
        m_unf = 0;
        phase = f ? 2 : 0;
      end else begin
        phase = 0;
      end
    end else begin
      ra  = r && n > 0 && !f;
      wa  = w && (n < 8 || ra) && !f;
      e.v = mk(wa, ra, 0, n, m_ovf, m_unf);
      e.rd = ra;
      if (ra)
        e.data = mq[0];
      if (w && !wa && !f)
        m_ovf = 1;
      if (r && !ra && !f)
        m_unf = 1;
      if (ra)
        void'(mq.pop_front());
      if (wa)
        mq.push_back(d);
      phase = f ? 2 : 0;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  always @(negedge clk) begin
    exp_t        e;
    logic [16:0] act;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      act = {wr_ack, wren, WrInc, rd_ack, rden, RdInc,
             WrPtrClr, RdPtrClr, count, full, empty,
             almost_full, overflow, underflow};
      checks++;
      if (act !== e.v) begin
        errors++;
        $display("FAIL strobes_flags cyc=%0d got=%b expected=%b",
                 e.cyc, act, e.v);
      end
      if (e.rd) begin
        checks++;
        if (dout !== e.data) begin
          errors++;
          $display("FAIL read_data cyc=%0d got=%h expected=%h",
                   e.cyc, dout, e.data);
        end
      end
    end
  end

  initial begin
    rst_n  = 1'b0;
    wr_req = 1'b0;
    rd_req = 1'b0;
    flush  = 1'b0;
    din    = 9'd0;
    phase  = 1;
    m_ovf  = 0;
    m_unf  = 0;
    @(posedge clk);
    #1;
    step(0, 0, 0, 0, 9'd0);
    step(0, 0, 0, 0, 9'd0);
    step(0, 0, 0, 1, 9'd0);
    step(0, 0, 0, 1, 9'd0);
    for (int i = 1; i <= 9; i++)
      step(1, 0, 0, 1, 9'h100 + 9'(i));
    for (int i = 0; i < 8; i++)
      step(0, 1, 0, 1, 9'd0);
    for (int i = 0; i < 8; i++)
      step(1, 0, 0, 1, 9'h110 + 9'(i));
    for (int i = 0; i < 3; i++)
      step(1, 1, 0, 1, 9'h1AA + 9'(i));
    for (int i = 0; i < 8; i++)
      step(0, 1, 0, 1, 9'd0);
    step(1, 1, 0, 1, 9'h0AA);
    step(0, 1, 0, 1, 9'd0);
    for (int i = 0; i < 9; i++)
      step(1, 0, 0, 1, 9'h020 + 9'(i));
    for (int i = 0; i < 3; i++)
      step(0, 1, 0, 1, 9'd0);
    step(1, 1, 1, 1, 9'h077);
    step(0, 0, 0, 1, 9'd0);
    step(1, 0, 0, 1, 9'h055);
    step(0, 1, 0, 1, 9'd0);
    for (int i = 0; i < 4; i++)
      step(1, 0, 0, 1, 9'h040 + 9'(i));
    wr_req = 1'b1;
    #1;
    checks++;
    if (wr_ack !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_ack got=%b expected=1", wr_ack);
    end
    step(1, 0, 0, 0, 9'h0EE);
    step(0, 0, 0, 1, 9'd0);
    step(1, 0, 0, 1, 9'h0C3);
    step(0, 1, 0, 1, 9'd0);
    for (int i = 0; i < 500; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 19) == 0, 1'b1, 9'($urandom));
    wr_req = 1'b0;
    rd_req = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d pending expected=0",
               exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
